// File: rtl/lightio_tx_queue_if.sv
// Host-write and encoder-transmit signal bundle for lightio_tx_queue.
// slave = the queue itself; master = host/encoder side driving it.
`ifndef FRAME_SIZE
`define FRAME_SIZE 8
`endif

interface lightio_tx_queue_if #(
    parameter int WIDTH = `FRAME_SIZE
);
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             tx_enable;
    logic [WIDTH-1:0] tx_data;
    logic             irq_tx;

    modport slave  (input  wr_valid, wr_data, irq_tx,
                    output wr_ready, tx_enable, tx_data);
    modport master (output wr_valid, wr_data, irq_tx,
                    input  wr_ready, tx_enable, tx_data);
endinterface

// File: rtl/lightio_tx_queue.sv
// Purpose: DEPTH-frame TX queue feeding the encoder one frame per irq_tx; LIGHTIO_TX_GAP_EN adds an idle gap.
// Latency: frame written at edge k launches (tx_enable) after edge k+1; next frame one edge after irq_tx sampled.
// Backpressure: wr_ready = !full from registered count only; writes while full set sticky overflow.
`ifndef FRAME_SIZE
`define FRAME_SIZE 8
`endif

module lightio_tx_queue #(
    parameter int WIDTH      = `FRAME_SIZE,
    parameter int DEPTH_LOG2 = 2,
    parameter int GAP_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    lightio_tx_queue_if.slave     bus,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
`ifdef LIGHTIO_TX_GAP_EN
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`endif

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  tx_enable_q, tx_enable_d;
    logic [WIDTH-1:0]      tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;
    logic                  overflow_q, overflow_d;
    logic                  full, empty, enq, deq;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign enq   = bus.wr_valid & ~full;

    always_comb begin
        state_d     = state_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        tx_enable_d = 1'b0;
        tx_data_d   = tx_data_q;
        overflow_d  = overflow_q | (bus.wr_valid & full);
        deq         = 1'b0;
`ifdef LIGHTIO_TX_GAP_EN
        gap_cnt_d   = gap_cnt_q;
`endif
        if (enq) begin
            wptr_d = wptr_q + DEPTH_LOG2'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    deq         = 1'b1;
                    tx_data_d   = mem_q[rptr_q];
                    rptr_d      = rptr_q + DEPTH_LOG2'(1);
                    tx_enable_d = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // irq_tx in the launch cycle lands here too, so it is never lost.
                if (bus.irq_tx) begin
`ifdef LIGHTIO_TX_GAP_EN
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GW'(GAP_CYCLES - 1);
                    end else begin
                        state_d   = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef LIGHTIO_TX_GAP_EN
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            tx_enable_q <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            tx_enable_q <= tx_enable_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef LIGHTIO_TX_GAP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`else
    logic unused_gap;
    assign unused_gap = (GAP_CYCLES != 0);
`endif

    // Storage needs no reset: only entries behind wptr are ever read.
    always_ff @(posedge clock) begin
        if (enq) begin
            mem_q[wptr_q] <= bus.wr_data;
        end
    end

    assign bus.wr_ready  = ~full;
    assign bus.tx_enable = tx_enable_q;
    assign bus.tx_data   = tx_data_q;
    assign busy          = busy_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
endmodule
